// File: rtl/irs_bm_pkg.sv
// Shared types and helpers for the IRS block manager.
package irs_bm_pkg;

    localparam int unsigned PAIR_BITS = 8;
    localparam int unsigned SLOT_BITS = 2;

    typedef logic [PAIR_BITS-1:0] pair_t;

    typedef struct packed {
        logic  active;
        logic  closed;
        pair_t start_pair;
        pair_t end_pair;
    } slot_t;

    typedef enum logic [1:0] {StIdle, StSearch, StReady, StFull} state_e;

    // Modulo-256 inclusive range test; end < start means the range wraps.
    function automatic logic pair_in_range(pair_t p, pair_t s, pair_t e);
        if (s <= e) return (p >= s) && (p <= e);
        return (p >= s) || (p <= e);
    endfunction

endpackage

// File: rtl/irs_block_manager_if.sv
// Write-controller and readout handshake bundle of the IRS block manager.
interface irs_block_manager_if;
    import irs_bm_pkg::*;

    logic                 wr_phase_i;
    logic                 wr_ack_i;
    logic [PAIR_BITS:0]   block_o;
    logic                 wr_enable_o;
    logic                 ev_valid_o;
    logic [SLOT_BITS-1:0] ev_slot_o;
    pair_t                ev_start_o;
    logic                 ev_ack_i;

    modport master (
        output wr_phase_i, wr_ack_i, ev_ack_i,
        input  block_o, wr_enable_o, ev_valid_o, ev_slot_o, ev_start_o
    );

    modport slave (
        input  wr_phase_i, wr_ack_i, ev_ack_i,
        output block_o, wr_enable_o, ev_valid_o, ev_slot_o, ev_start_o
    );

endinterface

// File: rtl/irs_bm_hold_slot.sv
// One trigger hold slot: range registers, post-trigger countdown and skip compare.
module irs_bm_hold_slot
    import irs_bm_pkg::*;
#(
    parameter int unsigned POSTTRIG = 8
) (
    input  logic  clk_i,
    input  logic  rst_i,
    input  logic  alloc_i,
    input  pair_t start_i,
    input  logic  release_i,
    input  logic  advance_i,
    input  pair_t ptr_i,
    input  pair_t cand_i,
    output slot_t slot_o,
    output logic  open_o,
    output logic  hit_o,
    output logic  close_o
);

    slot_t slot_q;
    pair_t post_cnt_q;

    assign slot_o  = slot_q;
    assign open_o  = slot_q.active & ~slot_q.closed;
    assign close_o = open_o & advance_i & (post_cnt_q == '0);
    assign hit_o   = slot_q.active & slot_q.closed &
                     pair_in_range(cand_i, slot_q.start_pair, slot_q.end_pair);

    // An open slot ignores release; the top only raises release_i for closed slots anyway.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            slot_q     <= '0;
            post_cnt_q <= '0;
        end else if (alloc_i) begin
            slot_q     <= '{active: 1'b1, closed: 1'b0, start_pair: start_i, end_pair: start_i};
            post_cnt_q <= pair_t'(POSTTRIG);
        end else if (close_o) begin
            slot_q.closed   <= 1'b1;
            slot_q.end_pair <= ptr_i;
        end else if (open_o && advance_i) begin
            post_cnt_q <= post_cnt_q - 1'b1;
        end else if (release_i && slot_q.closed) begin
            slot_q.active <= 1'b0;
        end
    end

endmodule

// File: rtl/irs_block_manager.sv
// Block scheduler for the IRS write controller: pair pointer, skip search,
// trigger hold allocation and hold-event reporting.
module irs_block_manager
    import irs_bm_pkg::*;
#(
    parameter int unsigned NUM_HOLDS = 4,
    parameter int unsigned PRETRIG   = 8,
    parameter int unsigned POSTTRIG  = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 enable_i,
    input  logic                 trig_i,
    input  logic                 release_i,
    input  logic [SLOT_BITS-1:0] release_slot_i,
    output logic                 full_o,
    output logic                 trig_dropped_o,
    irs_block_manager_if.slave   bus
);

    state_e               state_q;
    pair_t                pair_ptr_q, cand_q, ev_start_q;
    logic [2:0]           search_cnt_q;
    logic                 full_q, wr_enable_q, trig_dropped_q, ev_valid_q;
    logic [SLOT_BITS-1:0] ev_slot_q;

    slot_t                slot [NUM_HOLDS];
    logic [NUM_HOLDS-1:0] slot_open, slot_hit, slot_close, slot_rel, slot_free, slot_alloc;
    logic                 pair_ack, advance, hit_any, close_any;
    pair_t                hit_end, close_start, alloc_start;
    logic [SLOT_BITS-1:0] close_slot;

    assign pair_ack    = bus.wr_ack_i & bus.wr_phase_i;
    assign advance     = pair_ack & (state_q == StReady);
    assign alloc_start = pair_ptr_q - pair_t'(PRETRIG);

    for (genvar s = 0; s < NUM_HOLDS; s++) begin : g_slot
        assign slot_rel[s]  = release_i & (release_slot_i == SLOT_BITS'(s)) &
                              slot[s].active & slot[s].closed;
        // A slot released this clock is already free for a same-clock trigger.
        assign slot_free[s] = ~slot[s].active | slot_rel[s];

        irs_bm_hold_slot #(
            .POSTTRIG (POSTTRIG)
        ) u_slot (
            .clk_i     (clk_i),
            .rst_i     (rst_i),
            .alloc_i   (slot_alloc[s]),
            .start_i   (alloc_start),
            .release_i (slot_rel[s]),
            .advance_i (advance),
            .ptr_i     (pair_ptr_q),
            .cand_i    (cand_q),
            .slot_o    (slot[s]),
            .open_o    (slot_open[s]),
            .hit_o     (slot_hit[s]),
            .close_o   (slot_close[s])
        );
    end

    // Descending scan so the lowest-index slot wins every selection.
    always_comb begin
        hit_any     = 1'b0;
        hit_end     = '0;
        close_any   = 1'b0;
        close_slot  = '0;
        close_start = '0;
        slot_alloc  = '0;
        for (int s = NUM_HOLDS - 1; s >= 0; s--) begin
            if (slot_hit[s]) begin
                hit_any = 1'b1;
                hit_end = slot[s].end_pair;
            end
            if (slot_close[s]) begin
                close_any   = 1'b1;
                close_slot  = SLOT_BITS'(s);
                close_start = slot[s].start_pair;
            end
            if (slot_free[s]) begin
                slot_alloc    = '0;
                slot_alloc[s] = 1'b1;
            end
        end
        if (!trig_i || (|slot_open)) slot_alloc = '0;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q        <= StIdle;
            pair_ptr_q     <= '0;
            cand_q         <= '0;
            search_cnt_q   <= '0;
            full_q         <= 1'b0;
            wr_enable_q    <= 1'b0;
            trig_dropped_q <= 1'b0;
            ev_valid_q     <= 1'b0;
            ev_slot_q      <= '0;
            ev_start_q     <= '0;
        end else begin
            trig_dropped_q <= trig_i & ~(|slot_alloc);

            if (close_any) begin
                ev_valid_q <= 1'b1;
                ev_slot_q  <= close_slot;
                ev_start_q <= close_start;
            end else if (bus.ev_ack_i) begin
                ev_valid_q <= 1'b0;
            end

            // Only retime on an even-block ack so the controller never splits a pair.
            if (!wr_enable_q || (bus.wr_ack_i && !bus.wr_phase_i)) begin
                wr_enable_q <= enable_i & ~full_q;
            end

            unique case (state_q)
                StIdle: begin
                    if (enable_i) begin
                        state_q      <= StSearch;
                        cand_q       <= pair_ptr_q + 1'b1;
                        search_cnt_q <= '0;
                    end
                end
                StSearch: begin
                    if (hit_any) begin
                        cand_q       <= hit_end + 1'b1;
                        search_cnt_q <= search_cnt_q + 1'b1;
                        if (search_cnt_q == 3'(NUM_HOLDS)) begin
                            state_q <= StFull;
                            full_q  <= 1'b1;
                        end else if (pair_ack) begin
                            full_q <= 1'b1;
                        end
                    end else if (cand_q == pair_ptr_q) begin
                        state_q <= StFull;
                        full_q  <= 1'b1;
                    end else begin
                        state_q <= StReady;
                        full_q  <= pair_ack;
                    end
                end
                StReady: begin
                    full_q <= 1'b0;
                    if (advance) begin
                        pair_ptr_q   <= cand_q;
                        cand_q       <= cand_q + 1'b1;
                        search_cnt_q <= '0;
                        state_q      <= StSearch;
                    end
                end
                StFull: begin
                    if (release_i) begin
                        state_q      <= StSearch;
                        cand_q       <= pair_ptr_q + 1'b1;
                        search_cnt_q <= '0;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.block_o     = {pair_ptr_q, bus.wr_phase_i};
    assign bus.wr_enable_o = wr_enable_q;
    assign bus.ev_valid_o  = ev_valid_q;
    assign bus.ev_slot_o   = ev_slot_q;
    assign bus.ev_start_o  = ev_start_q;
    assign full_o          = full_q;
    assign trig_dropped_o  = trig_dropped_q;

endmodule

// File: tb/tb_irs_block_manager.sv
// Directed bench: default-parameter manager for run/hold/drop/reset, and a
// two-slot wide-window manager for the full/release path.
module tb_irs_block_manager;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b1;
    logic       enable_i = 1'b1;
    logic       trig1 = 1'b0, rel1 = 1'b0, full1, drop1;
    logic       trig2 = 1'b0, rel2 = 1'b0, full2, drop2;
    logic [1:0] rel_slot1 = 2'd0, rel_slot2 = 2'd0;
    int         n_checks = 0;
    int         n_errors = 0;
    logic [7:0] p;

    always #5 clk_i = ~clk_i;

    irs_block_manager_if if1 ();
    irs_block_manager_if if2 ();

    irs_block_manager u_dut1 (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .enable_i       (enable_i),
        .trig_i         (trig1),
        .release_i      (rel1),
        .release_slot_i (rel_slot1),
        .full_o         (full1),
        .trig_dropped_o (drop1),
        .bus            (if1)
    );

    irs_block_manager #(
        .NUM_HOLDS (2),
        .PRETRIG   (120),
        .POSTTRIG  (10)
    ) u_dut2 (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .enable_i       (enable_i),
        .trig_i         (trig2),
        .release_i      (rel2),
        .release_slot_i (rel_slot2),
        .full_o         (full2),
        .trig_dropped_o (drop2),
        .bus            (if2)
    );

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [8:0] blk(input bit which);
        return which ? if2.block_o : if1.block_o;
    endfunction

    task automatic set_ack(input bit which, input logic ph, input logic ack);
        if (which) begin
            if2.wr_phase_i = ph;
            if2.wr_ack_i   = ack;
        end else begin
            if1.wr_phase_i = ph;
            if1.wr_ack_i   = ack;
        end
    endtask

    // Even ack, two clocks, odd ack, two clocks: one pair advance every 4 clocks.
    task automatic write_pair(input bit which, input logic [7:0] exp);
        @(negedge clk_i);
        set_ack(which, 1'b0, 1'b1);
        #1 chk("block_even", 16'(blk(which)), 16'({exp, 1'b0}));
        @(negedge clk_i);
        set_ack(which, 1'b0, 1'b0);
        @(negedge clk_i);
        set_ack(which, 1'b1, 1'b1);
        #1 chk("block_odd", 16'(blk(which)), 16'({exp, 1'b1}));
        @(negedge clk_i);
        set_ack(which, 1'b1, 1'b0);
    endtask

    task automatic pulse_trig(input bit which, input logic exp_drop, input string tag);
        @(negedge clk_i);
        if (which) trig2 = 1'b1;
        else trig1 = 1'b1;
        @(negedge clk_i);
        trig1 = 1'b0;
        trig2 = 1'b0;
        chk(tag, 16'(which ? drop2 : drop1), 16'(exp_drop));
    endtask

    task automatic ack_event(input bit which);
        @(negedge clk_i);
        if (which) if2.ev_ack_i = 1'b1;
        else if1.ev_ack_i = 1'b1;
        @(negedge clk_i);
        if1.ev_ack_i = 1'b0;
        if2.ev_ack_i = 1'b0;
        chk("ev_cleared", 16'(which ? if2.ev_valid_o : if1.ev_valid_o), 16'd0);
    endtask

    task automatic chk_event(input logic [1:0] slot, input logic [7:0] start);
        chk("ev_valid", 16'(if1.ev_valid_o), 16'd1);
        chk("ev_slot", 16'(if1.ev_slot_o), 16'(slot));
        chk("ev_start", 16'(if1.ev_start_o), 16'(start));
    endtask

    initial begin
        set_ack(1'b0, 1'b0, 1'b0);
        set_ack(1'b1, 1'b0, 1'b0);
        if1.ev_ack_i = 1'b0;
        if2.ev_ack_i = 1'b0;

        // Reset values
        repeat (2) @(negedge clk_i);
        chk("rst_block_ph0", 16'(if1.block_o), 16'h000);
        if1.wr_phase_i = 1'b1;
        #1 chk("rst_block_ph1", 16'(if1.block_o), 16'h001);
        if1.wr_phase_i = 1'b0;
        chk("rst_wr_enable", 16'(if1.wr_enable_o), 16'd0);
        chk("rst_ev_valid", 16'(if1.ev_valid_o), 16'd0);
        chk("rst_full", 16'(full1), 16'd0);
        chk("rst_drop", 16'(drop1), 16'd0);
        @(negedge clk_i);
        rst_i = 1'b0;
        repeat (4) @(negedge clk_i);
        chk("run_wr_enable", 16'(if1.wr_enable_o), 16'd1);

        // Free run through all 256 pairs and back to 0
        for (int i = 0; i < 256; i++) write_pair(1'b0, 8'(i));
        chk("wrap_ptr", 16'(if1.block_o[8:1]), 16'd0);

        // Single hold: trigger at pair 20, window 12..28
        for (int i = 0; i < 20; i++) write_pair(1'b0, 8'(i));
        pulse_trig(1'b0, 1'b0, "trig_accept");
        for (int i = 20; i < 23; i++) write_pair(1'b0, 8'(i));
        pulse_trig(1'b0, 1'b1, "trig_in_window");
        @(negedge clk_i);
        chk("drop_one_clock", 16'(drop1), 16'd0);
        for (int i = 23; i < 28; i++) write_pair(1'b0, 8'(i));
        chk("ev_before_close", 16'(if1.ev_valid_o), 16'd0);
        write_pair(1'b0, 8'd28);
        chk_event(2'd0, 8'd12);
        ack_event(1'b0);

        // Wrap: pairs 12..28 are skipped, 11 is followed by 29
        p = 8'd29;
        for (int n = 0; n < 239; n++) begin
            write_pair(1'b0, p);
            p = p + 8'd1;
            if (p >= 8'd12 && p <= 8'd28) p = 8'd29;
        end
        chk("skip_to_29", 16'(if1.block_o[8:1]), 16'd29);

        // Fill remaining slots: [21,37], [30,46], [39,55]
        for (int k = 1; k < 4; k++) begin
            pulse_trig(1'b0, 1'b0, "trig_fill");
            for (int i = 0; i < 9; i++) begin
                write_pair(1'b0, p);
                p = p + 8'd1;
            end
            chk_event(2'(k), p - 8'd17);
            ack_event(1'b0);
        end
        chk("ptr_56", 16'(if1.block_o[8:1]), 16'd56);
        pulse_trig(1'b0, 1'b1, "trig_all_full");
        for (int i = 0; i < 9; i++) begin
            write_pair(1'b0, p);
            p = p + 8'd1;
        end
        chk("no_event_after_drop", 16'(if1.ev_valid_o), 16'd0);

        // Same-clock trigger and release of slot 2 at pair 65
        @(negedge clk_i);
        trig1 = 1'b1;
        rel1 = 1'b1;
        rel_slot1 = 2'd2;
        @(negedge clk_i);
        trig1 = 1'b0;
        rel1 = 1'b0;
        chk("trig_rel_no_drop", 16'(drop1), 16'd0);
        for (int i = 0; i < 9; i++) begin
            write_pair(1'b0, p);
            p = p + 8'd1;
        end
        chk_event(2'd2, 8'd57);

        // Full: second instance, holds [0,130] and [124,254] leave only pair 255
        for (int i = 0; i < 120; i++) write_pair(1'b1, 8'(i));
        pulse_trig(1'b1, 1'b0, "trig2_a");
        for (int i = 120; i < 131; i++) write_pair(1'b1, 8'(i));
        chk("ev2_start_a", 16'(if2.ev_start_o), 16'd0);
        ack_event(1'b1);
        for (int i = 131; i < 244; i++) write_pair(1'b1, 8'(i));
        pulse_trig(1'b1, 1'b0, "trig2_b");
        for (int i = 244; i < 255; i++) write_pair(1'b1, 8'(i));
        chk("ev2_start_b", 16'(if2.ev_start_o), 16'd124);
        ack_event(1'b1);
        repeat (4) @(negedge clk_i);
        chk("full_set", 16'(full2), 16'd1);
        chk("full_ptr", 16'(if2.block_o[8:1]), 16'd255);
        set_ack(1'b1, 1'b0, 1'b1);
        @(negedge clk_i);
        set_ack(1'b1, 1'b0, 1'b0);
        chk("full_wr_enable_low", 16'(if2.wr_enable_o), 16'd0);
        @(negedge clk_i);
        rel2 = 1'b1;
        rel_slot2 = 2'd0;
        @(negedge clk_i);
        rel2 = 1'b0;
        repeat (5) @(negedge clk_i);
        chk("full_cleared", 16'(full2), 16'd0);
        chk("wr_enable_back", 16'(if2.wr_enable_o), 16'd1);
        write_pair(1'b1, 8'd255);
        chk("ptr_freed_range", 16'(if2.block_o[8:1]), 16'd0);

        // Reset while the first instance is searching, with its event still pending
        chk("ev_pending", 16'(if1.ev_valid_o), 16'd1);
        @(negedge clk_i);
        set_ack(1'b0, 1'b0, 1'b1);
        @(negedge clk_i);
        set_ack(1'b0, 1'b0, 1'b0);
        @(negedge clk_i);
        set_ack(1'b0, 1'b1, 1'b1);
        @(posedge clk_i);
        #1 rst_i = 1'b1;
        #1;
        chk("mid_rst_block", 16'(if1.block_o), 16'h001);
        chk("mid_rst_wr_enable", 16'(if1.wr_enable_o), 16'd0);
        chk("mid_rst_ev_valid", 16'(if1.ev_valid_o), 16'd0);
        chk("mid_rst_full", 16'(full1), 16'd0);
        chk("mid_rst_drop", 16'(drop1), 16'd0);
        set_ack(1'b0, 1'b1, 1'b0);
        @(negedge clk_i);
        rst_i = 1'b0;
        repeat (2) @(negedge clk_i);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
